// File: rtl/svd_cordic_pkg.sv
// Shared constants and types for the CORDIC sign-replay rotator used in the SVD sweep.
package svd_cordic_pkg;

    localparam int DEF_WIDTH     = 24;
    localparam int DEF_SHIFT_BIT = 4;
    localparam int DEF_N_ITER    = 16;
    localparam int LANES         = 8;

    // Shift taps of the 1/K gain approximation: (v>>>1)+(v>>>3)-(v>>>6)-(v>>>9)
    localparam int GAIN_SH0 = 1;
    localparam int GAIN_SH1 = 3;
    localparam int GAIN_SH2 = 6;
    localparam int GAIN_SH3 = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROT   = 2'd2,
        ST_SCALE = 2'd3
    } rep_state_e;

endpackage

// File: rtl/cordic_replay_lane.sv
// One combinational CORDIC micro-rotation of an x/y pair, direction taken from a replayed sign bit.
module cordic_replay_lane
    import svd_cordic_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int WIDTH_SHIFT_BIT = DEF_SHIFT_BIT
) (
    input  logic signed [WIDTH-1:0]           x,
    input  logic signed [WIDTH-1:0]           y,
    input  logic        [WIDTH_SHIFT_BIT-1:0] shift,
    input  logic                              sign,
    output logic signed [WIDTH-1:0]           x_next,
    output logic signed [WIDTH-1:0]           y_next
);

    logic signed [WIDTH-1:0] x_sh_s;
    logic signed [WIDTH-1:0] y_sh_s;

    // sign=1 rotates clockwise, sign=0 counter-clockwise; sums wrap at WIDTH bits
    always_comb begin
        x_sh_s = x >>> shift;
        y_sh_s = y >>> shift;
        if (sign) begin
            x_next = x + y_sh_s;
            y_next = y - x_sh_s;
        end else begin
            x_next = x - y_sh_s;
            y_next = y + x_sh_s;
        end
    end

endmodule

// File: rtl/cordic_rot_replay.sv
// Captures a vectoring pass's sign stream and replays it as rotations on 8 x/y lanes.
// Optional CORDIC_GAIN_COMP_EN adds a one-cycle 1/K gain-compensation stage after the rotations.
module cordic_rot_replay
    import svd_cordic_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int WIDTH_SHIFT_BIT = DEF_SHIFT_BIT,
    parameter int N_ITER          = DEF_N_ITER
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sign_valid,
    input  logic                       sign_first,
    input  logic                       sign_in,
    input  logic                       sign_flip,
    output logic                       sign_ready,
    output logic                       signs_full,
    output logic                       sign_ovf,
    input  logic                       start,
    input  logic [2*LANES*WIDTH-1:0]   data_in,
    output logic                       busy,
    output logic                       done,
    output logic [2*LANES*WIDTH-1:0]   data_out
);

    localparam int BUS_W = 2 * LANES * WIDTH;
    localparam int PTR_W = WIDTH_SHIFT_BIT + 1;
    localparam int TAB_D = 1 << WIDTH_SHIFT_BIT;
    localparam logic [PTR_W-1:0]           PTR_FULL = PTR_W'(N_ITER);
    localparam logic [PTR_W-1:0]           PTR_ONE  = PTR_W'(1);
    localparam logic [WIDTH_SHIFT_BIT-1:0] IT_LAST  = WIDTH_SHIFT_BIT'(N_ITER - 1);
    localparam logic [WIDTH_SHIFT_BIT-1:0] IT_ONE   = WIDTH_SHIFT_BIT'(1);

    rep_state_e                  state_r;
    rep_state_e                  state_next_s;
    logic [TAB_D-1:0]            sign_tab_r;
    logic [PTR_W-1:0]            wptr_r;
    logic                        flip_r;
    logic                        signs_full_r;
    logic                        sign_ovf_r;
    logic                        sign_ready_r;
    logic                        busy_r;
    logic                        done_r;
    logic [WIDTH_SHIFT_BIT-1:0]  it_r;
    logic [BUS_W-1:0]            data_out_r;
    logic [BUS_W-1:0]            result_s;
    logic                        load_s;
    logic                        rot_s;
    logic                        finish_s;
    logic signed [WIDTH-1:0]     x_r     [LANES];
    logic signed [WIDTH-1:0]     y_r     [LANES];
    logic signed [WIDTH-1:0]     x_in_s  [LANES];
    logic signed [WIDTH-1:0]     y_in_s  [LANES];
    logic signed [WIDTH-1:0]     x_rot_s [LANES];
    logic signed [WIDTH-1:0]     y_rot_s [LANES];

    function automatic logic signed [WIDTH-1:0] gain_comp(input logic signed [WIDTH-1:0] v);
        return (v >>> GAIN_SH0) + (v >>> GAIN_SH1) - (v >>> GAIN_SH2) - (v >>> GAIN_SH3);
    endfunction

    assign sign_ready = sign_ready_r;
    assign signs_full = signs_full_r;
    assign sign_ovf   = sign_ovf_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign data_out   = data_out_r;

    // State register with registered busy/ready derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            sign_ready_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
            sign_ready_r <= (state_next_s == ST_IDLE);
        end
    end

    // Next-state logic; a start coinciding with a sign write is dropped
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && signs_full_r && !sign_valid) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: state_next_s = ST_ROT;
            ST_ROT: begin
                if (it_r == IT_LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_next_s = ST_SCALE;
`else
                    state_next_s = ST_IDLE;
`endif
                end else begin
                    state_next_s = ST_ROT;
                end
            end
            ST_SCALE: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Datapath controls decoded from the current state
    always_comb begin
        load_s   = 1'b0;
        rot_s    = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_LOAD: load_s = 1'b1;
            ST_ROT: begin
                rot_s = 1'b1;
`ifdef CORDIC_GAIN_COMP_EN
                finish_s = 1'b0;
`else
                finish_s = (it_r == IT_LAST);
`endif
            end
            ST_SCALE: begin
`ifdef CORDIC_GAIN_COMP_EN
                finish_s = 1'b1;
`else
                finish_s = 1'b0;
`endif
            end
            default: load_s = 1'b0;
        endcase
    end

    // Sign capture, only while idle; a full table drops further bits and flags overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_tab_r   <= '0;
            wptr_r       <= '0;
            flip_r       <= 1'b0;
            signs_full_r <= 1'b0;
            sign_ovf_r   <= 1'b0;
        end else if (sign_ready_r && sign_valid) begin
            if (sign_first) begin
                sign_tab_r[0] <= sign_in;
                wptr_r        <= PTR_ONE;
                flip_r        <= sign_flip;
                sign_ovf_r    <= 1'b0;
                signs_full_r  <= (PTR_ONE == PTR_FULL);
            end else if (wptr_r < PTR_FULL) begin
                sign_tab_r[wptr_r[WIDTH_SHIFT_BIT-1:0]] <= sign_in;
                wptr_r       <= wptr_r + PTR_ONE;
                signs_full_r <= ((wptr_r + PTR_ONE) == PTR_FULL);
            end else begin
                sign_ovf_r <= 1'b1;
            end
        end
    end

    // Load operands, negating both coordinates when the pass asked for a pi pre-rotation
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            x_in_s[i] = $signed(data_in[i*WIDTH +: WIDTH]);
            y_in_s[i] = $signed(data_in[(LANES+i)*WIDTH +: WIDTH]);
            if (flip_r) begin
                x_in_s[i] = -x_in_s[i];
                y_in_s[i] = -y_in_s[i];
            end else begin
                x_in_s[i] = x_in_s[i];
                y_in_s[i] = y_in_s[i];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        cordic_replay_lane #(
            .WIDTH           (WIDTH),
            .WIDTH_SHIFT_BIT (WIDTH_SHIFT_BIT)
        ) u_lane (
            .x      (x_r[g]),
            .y      (y_r[g]),
            .shift  (it_r),
            .sign   (sign_tab_r[it_r]),
            .x_next (x_rot_s[g]),
            .y_next (y_rot_s[g])
        );
    end

    // Result word: last rotation output, or gain-compensated lanes in the SCALE cycle
    always_comb begin
        result_s = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef CORDIC_GAIN_COMP_EN
            result_s[i*WIDTH +: WIDTH]         = gain_comp(x_r[i]);
            result_s[(LANES+i)*WIDTH +: WIDTH] = gain_comp(y_r[i]);
`else
            result_s[i*WIDTH +: WIDTH]         = x_rot_s[i];
            result_s[(LANES+i)*WIDTH +: WIDTH] = y_rot_s[i];
`endif
        end
    end

    // Lane registers, iteration counter, done pulse and held output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                x_r[i] <= '0;
                y_r[i] <= '0;
            end
            it_r       <= '0;
            done_r     <= 1'b0;
            data_out_r <= '0;
        end else begin
            if (load_s) begin
                for (int i = 0; i < LANES; i++) begin
                    x_r[i] <= x_in_s[i];
                    y_r[i] <= y_in_s[i];
                end
                it_r <= '0;
            end else if (rot_s) begin
                for (int i = 0; i < LANES; i++) begin
                    x_r[i] <= x_rot_s[i];
                    y_r[i] <= y_rot_s[i];
                end
                it_r <= it_r + IT_ONE;
            end
            done_r <= finish_s;
            if (finish_s) begin
                data_out_r <= result_s;
            end
        end
    end

endmodule
